// File: rtl/hilo_md_ctrl.sv
// Sequencer for the shared multiply/divide unit: issues one op at a time, stalls the pipeline,
// and returns a one-cycle HI/LO result pulse.
module hilo_md_ctrl #(
    parameter int unsigned MUL_LAT  = 2,
    parameter bit          DIV_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        op_valid,
    input  logic        op_mul,
    input  logic        op_div,
    input  logic        op_signed,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_annul,
    output logic        div_signed,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        stall_req,
    output logic        res_valid,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        busy
);

    localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_BUSY, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        opa, opb;
    logic               ops;
    logic               load;
    logic [31:0]        hi_q, lo_q, hi_nxt, lo_nxt;

    // State, counter, operand and result registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            ops   <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            if (load) begin
                opa <= src_a;
                opb <= src_b;
                ops <= op_signed;
            end
        end
    end

    // Next-state, result capture and combinational handshake outputs
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi_q;
        lo_nxt    = lo_q;
        load      = 1'b0;
        stall_req = 1'b0;
        div_start = 1'b0;
        div_annul = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid && !flush && (op_mul || op_div)) begin
                    stall_req = 1'b1;
                    load      = 1'b1;
                    if (op_mul) begin
                        state_nxt = MUL_WAIT;
                        cnt_nxt   = CNT_W'(MUL_LAT - 1);
                    end else if (DIV_ZERO && (src_b == 32'd0)) begin
                        state_nxt = DONE;
                        hi_nxt    = '0;
                        lo_nxt    = '0;
                    end else begin
                        state_nxt = DIV_BUSY;
                    end
                end
            end
            MUL_WAIT: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    stall_req = 1'b1;
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else begin
                        hi_nxt    = mul_result[63:32];
                        lo_nxt    = mul_result[31:0];
                        state_nxt = DONE;
                    end
                end
            end
            DIV_BUSY: begin
                if (flush) begin
                    div_annul = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall_req = 1'b1;
                    div_start = !div_ready;
                    if (div_ready) begin
                        hi_nxt    = div_result[63:32];
                        lo_nxt    = div_result[31:0];
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                res_valid = !flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Combinational outputs stay quiet while reset is asserted
        if (!resetn) begin
            stall_req = 1'b0;
            div_start = 1'b0;
            div_annul = 1'b0;
            res_valid = 1'b0;
        end
    end

    assign mul_signed = ops;
    assign mul_ina    = opa;
    assign mul_inb    = opb;
    assign div_signed = ops;
    assign div_op1    = opa;
    assign div_op2    = opb;
    assign res_hi     = hi_q;
    assign res_lo     = lo_q;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Bench for hilo_md_ctrl: transaction-level model with per-cycle compare plus directed literal checks.
module tb_hilo_md_ctrl;

    localparam int unsigned MUL_LAT = 2;
    localparam int          DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        resetn, flush, op_valid, op_mul, op_div, op_signed;
    logic [31:0] src_a, src_b;
    logic        mul_signed, div_start, div_annul, div_signed, div_ready;
    logic [31:0] mul_ina, mul_inb, div_op1, div_op2;
    logic [63:0] mul_result, div_result;
    logic        stall_req, res_valid, busy;
    logic [31:0] res_hi, res_lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hilo_md_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ZERO(1'b1)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .op_valid(op_valid),
        .op_mul(op_mul), .op_div(op_div), .op_signed(op_signed),
        .src_a(src_a), .src_b(src_b),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
        .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
        .div_op1(div_op1), .div_op2(div_op2), .div_result(div_result), .div_ready(div_ready),
        .stall_req(stall_req), .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo), .busy(busy)
    );

    function automatic logic [63:0] f_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (s) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [63:0] f_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Multiplier stand-in: product of the registered operands
    assign mul_result = f_mul(mul_signed, mul_ina, mul_inb);

    // Divider stand-in: ready after DIV_LAT consecutive start cycles
    int dcnt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)         dcnt <= 0;
        else if (!div_start) dcnt <= 0;
        else                 dcnt <= dcnt + 1;
    end
    assign div_ready  = (dcnt == DIV_LAT);
    assign div_result = f_div(div_signed, div_op1, div_op2);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one op outstanding, known DONE cycle per op
    int          cyc = 0;
    logic        m_act = 1'b0;
    int          m_kind = 0;   // 0 mul, 1 div, 2 div-by-zero bypass
    int          m_done = -1;
    logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;
    logic        m_s = 1'b0;
    int          stall_cnt = 0, start_cnt = 0, annul_cnt = 0, rv_cnt = 0;
    logic [31:0] last_hi = '0, last_lo = '0;

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        logic e_stall, e_start, e_annul, e_rv, e_busy, issue;
        e_stall = 1'b0; e_start = 1'b0; e_annul = 1'b0; e_rv = 1'b0; e_busy = 1'b0; issue = 1'b0;
        if (!resetn) begin
            m_act = 1'b0; m_a = '0; m_b = '0; m_s = 1'b0;
            chk("rst_res_hi", 64'(res_hi), 64'd0);
            chk("rst_res_lo", 64'(res_lo), 64'd0);
        end else begin
            if (m_act && cyc == m_done) begin
                e_busy = 1'b1;
                e_rv   = !flush;
                if (!flush) begin
                    chk("res_hi", 64'(res_hi), 64'(m_hi));
                    chk("res_lo", 64'(res_lo), 64'(m_lo));
                end
                m_act = 1'b0;
            end else if (m_act) begin
                e_busy  = 1'b1;
                e_stall = !flush;
                e_start = (m_kind == 1) && !div_ready && !flush;
                e_annul = (m_kind == 1) && flush;
                if (flush) m_act = 1'b0;
                else if (m_kind == 1 && div_ready) m_done = cyc + 1;
            end else begin
                issue   = op_valid && !flush && (op_mul || op_div);
                e_stall = issue;
            end
        end
        chk("stall_req", 64'(stall_req), 64'(e_stall));
        chk("div_start", 64'(div_start), 64'(e_start));
        chk("div_annul", 64'(div_annul), 64'(e_annul));
        chk("res_valid", 64'(res_valid), 64'(e_rv));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("mul_ops", {mul_ina, mul_inb}, {m_a, m_b});
        chk("div_ops", {div_op1, div_op2}, {m_a, m_b});
        chk("signs", {62'd0, mul_signed, div_signed}, {62'd0, m_s, m_s});
        if (issue) begin
            m_act = 1'b1; m_a = src_a; m_b = src_b; m_s = op_signed;
            if (op_mul) begin
                m_kind = 0; m_done = cyc + int'(MUL_LAT) + 1;
                {m_hi, m_lo} = f_mul(op_signed, src_a, src_b);
            end else if (src_b == 32'd0) begin
                m_kind = 2; m_done = cyc + 1; m_hi = '0; m_lo = '0;
            end else begin
                m_kind = 1; m_done = -1;
                {m_hi, m_lo} = f_div(op_signed, src_a, src_b);
            end
        end
        if (stall_req) stall_cnt++;
        if (div_start) start_cnt++;
        if (div_annul) annul_cnt++;
        if (res_valid) begin rv_cnt++; last_hi = res_hi; last_lo = res_lo; end
        cyc++;
    end

    task automatic clear_mon();
        stall_cnt = 0; start_cnt = 0; annul_cnt = 0; rv_cnt = 0;
    endtask

    task automatic set_op(input logic m, input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; op_mul = m; op_div = d; op_signed = s; src_a = a; src_b = b;
    endtask

    task automatic idle_op();
        op_valid = 1'b0; op_mul = 1'b0; op_div = 1'b0; op_signed = 1'b0; src_a = '0; src_b = '0;
    endtask

    // EX behaviour: hold the op until its result pulse, then move on
    task automatic run_op(input logic m, input logic d, input logic s, input logic [31:0] a, input logic [31:0] b);
        logic seen;
        seen = 1'b0;
        set_op(m, d, s, a, b);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            seen = res_valid;
            @(posedge clk); #1;
            if (seen) break;
        end
        idle_op();
        if (!seen) begin
            checks++; errors++;
            $display("FAIL run_op_timeout: got no res_valid want one within 200 cycles");
        end
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; idle_op();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // multu 0xFFFFFFFF * 2
        clear_mon();
        run_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2);
        chk("t1_stall_cycles", 64'(stall_cnt), 64'd3);
        chk("t1_hi", 64'(last_hi), 64'h1);
        chk("t1_lo", 64'(last_lo), 64'hFFFF_FFFE);
        chk("t1_pulses", 64'(rv_cnt), 64'd1);

        // signed div -7 / 2
        clear_mon();
        run_op(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("t2_start_cycles", 64'(start_cnt), 64'd33);
        chk("t2_stall_cycles", 64'(stall_cnt), 64'd35);
        chk("t2_hi", 64'(last_hi), 64'hFFFF_FFFF);
        chk("t2_lo", 64'(last_lo), 64'hFFFF_FFFD);

        // divu by zero bypass
        clear_mon();
        run_op(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
        chk("t3_stall_cycles", 64'(stall_cnt), 64'd1);
        chk("t3_start_cycles", 64'(start_cnt), 64'd0);
        chk("t3_hi_lo", {last_hi, last_lo}, 64'd0);

        // flush five cycles into the divide
        clear_mon();
        set_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        repeat (6) begin @(posedge clk); #1; end
        idle_op(); flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(posedge clk); #1;
        chk("t4_annul_cycles", 64'(annul_cnt), 64'd1);
        chk("t4_no_result", 64'(rv_cnt), 64'd0);
        chk("t4_idle", 64'(busy), 64'd0);
        run_op(1'b1, 1'b0, 1'b0, 32'd6, 32'd7);
        chk("t4_after_mul", {last_hi, last_lo}, 64'd42);

        // reset during MUL_WAIT
        set_op(1'b1, 1'b0, 1'b1, 32'd3, 32'd4);
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("t5_rst_stall", 64'(stall_req), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_ops", {mul_ina, mul_inb}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1; idle_op();
        @(posedge clk); #1;
        clear_mon();
        run_op(1'b1, 1'b0, 1'b1, 32'd3, 32'd4);
        chk("t5_mult", {last_hi, last_lo}, 64'd12);

        // back-to-back mult then divu, op held through DONE
        clear_mon();
        run_op(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000);
        chk("t6_mul", {last_hi, last_lo}, 64'h0000_0001_0000_0000);
        run_op(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
        chk("t6_div", {last_hi, last_lo}, {32'd2, 32'd14});
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_pulses", 64'(rv_cnt), 64'd2);

        // flush coinciding with issue, and a non mul/div op
        clear_mon();
        set_op(1'b1, 1'b0, 1'b0, 32'd9, 32'd9); flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        set_op(1'b0, 1'b0, 1'b0, 32'd9, 32'd9);
        @(posedge clk); #1 idle_op();
        @(posedge clk); #1;
        chk("t7_no_stall", 64'(stall_cnt), 64'd0);
        chk("t7_idle", 64'(busy), 64'd0);

        // mul wins when both op_mul and op_div are set
        run_op(1'b1, 1'b1, 1'b0, 32'd5, 32'd3);
        chk("t8_priority", {last_hi, last_lo}, 64'd15);

        // flush during DONE suppresses the result
        clear_mon();
        set_op(1'b1, 1'b0, 1'b0, 32'd11, 32'd11);
        repeat (MUL_LAT + 1) begin @(posedge clk); #1; end
        idle_op(); flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(posedge clk); #1;
        chk("t9_suppressed", 64'(rv_cnt), 64'd0);
        chk("t9_idle", 64'(busy), 64'd0);

        // signed negative product
        run_op(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3);
        chk("t10_neg", {last_hi, last_lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
